cpu: RTL and testbench

Single-cycle 8-bit accumulator-style processor with four 8-bit general registers, a carry flag, a 4-bit program counter and an internal 16-word instruction ROM. Each clock edge executes exactly one instruction. All architectural state is exported on output ports for observation, so this is the top-level unit of the processor design.

---
 rtl/cpu.sv | 184 ++++++++++++++++++
 tb/tb_cpu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// -----------------------------------------------------------------------------
// cpu : single-cycle 8-bit accumulator-style processor
//
// Each rising clock edge executes the instruction found in the internal
// 16-word ROM at the current PC. Every piece of architectural state is
// exported so the processor can be watched from outside.
//
// Ports
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-high; clears PC, R0-R3 and carry
//   Instruction  out  8  ROM word at the current PC (combinational)
//   PC           out  4  program counter (registered)
//   R0..R3       out  8  general registers (registered)
//   ALUResult    out  8  result of the current instruction (combinational)
//   CarryOut     out  1  carry/borrow flag (registered)
//
// Instruction fields: opcode=[7:4], rd=[3:2], rs=[1:0], imm2=[1:0], addr4=[3:0]
// There is no handshake: one instruction retires on every edge outside reset.
// -----------------------------------------------------------------------------
module cpu (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] Instruction,
  output logic [3:0] PC,
  output logic [7:0] R0,
  output logic [7:0] R1,
  output logic [7:0] R2,
  output logic [7:0] R3,
  output logic [7:0] ALUResult,
  output logic       CarryOut
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_MOV  = 4'h7,
    OP_INC  = 4'h8,
    OP_DEC  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_LDI  = 4'hC,
    OP_JMP  = 4'hD,
    OP_JC   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Architectural state
  logic [3:0] r_pc;
  logic [7:0] r_regs [4];
  logic       r_carry;

  // Decode / datapath
  logic [7:0] w_instr;
  opcode_e    w_opcode;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_result;
  logic       w_reg_we;
  logic       w_carry_we;
  logic       w_carry_next;
  logic [3:0] w_pc_next;

  // Program ROM
  always_comb begin
    w_instr = 8'h00;
    case (r_pc)
      4'd0:  w_instr = 8'hC3;  // LDI R0,3
      4'd1:  w_instr = 8'hC6;  // LDI R1,2
      4'd2:  w_instr = 8'h11;  // ADD R0,R1
      4'd3:  w_instr = 8'h78;  // MOV R2,R0
      4'd4:  w_instr = 8'hAA;  // SHL R2,R2
      4'd5:  w_instr = 8'h29;  // SUB R2,R1
      4'd6:  w_instr = 8'h5E;  // XOR R3,R2
      4'd7:  w_instr = 8'h6F;  // NOT R3,R3
      4'd8:  w_instr = 8'h8C;  // INC R3
      4'd9:  w_instr = 8'h1E;  // ADD R3,R2
      4'd10: w_instr = 8'hEC;  // JC 12
      4'd11: w_instr = 8'h00;  // NOP
      4'd12: w_instr = 8'h94;  // DEC R1
      4'd13: w_instr = 8'h31;  // AND R0,R1
      4'd14: w_instr = 8'hFF;  // HALT
      default: w_instr = 8'h00;
    endcase
  end

  assign w_opcode = opcode_e'(w_instr[7:4]);
  assign w_rd     = w_instr[3:2];
  assign w_rs     = w_instr[1:0];

  // Both operands come from the pre-edge register file, so rd==rs is safe.
  assign w_a    = r_regs[w_rd];
  assign w_b    = r_regs[w_rs];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  // Bit 8 of the 9-bit difference is set exactly when a < b (borrow).
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_result     = 8'h00;
    w_reg_we     = 1'b0;
    w_carry_we   = 1'b0;
    w_carry_next = r_carry;
    w_pc_next    = r_pc + 4'd1;
    case (w_opcode)
      OP_NOP: ;
      OP_ADD: begin
        w_result     = w_sum[7:0];
        w_reg_we     = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = w_sum[8];
      end
      OP_SUB: begin
        w_result     = w_diff[7:0];
        w_reg_we     = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = w_diff[8];
      end
      OP_AND: begin w_result = w_a & w_b; w_reg_we = 1'b1; end
      OP_OR:  begin w_result = w_a | w_b; w_reg_we = 1'b1; end
      OP_XOR: begin w_result = w_a ^ w_b; w_reg_we = 1'b1; end
      OP_NOT: begin w_result = ~w_b;      w_reg_we = 1'b1; end
      OP_MOV: begin w_result = w_b;       w_reg_we = 1'b1; end
      OP_INC: begin
        w_result     = w_a + 8'd1;
        w_reg_we     = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = (w_a == 8'hFF);
      end
      OP_DEC: begin
        w_result     = w_a - 8'd1;
        w_reg_we     = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = (w_a == 8'h00);
      end
      OP_SHL: begin
        w_result     = {w_b[6:0], 1'b0};
        w_reg_we     = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = w_b[7];
      end
      OP_SHR: begin
        w_result     = {1'b0, w_b[7:1]};
        w_reg_we     = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = w_b[0];
      end
      OP_LDI: begin w_result = {6'b0, w_instr[1:0]}; w_reg_we = 1'b1; end
      OP_JMP: w_pc_next = w_instr[3:0];
      OP_JC:  if (r_carry) w_pc_next = w_instr[3:0];
      OP_HALT: w_pc_next = r_pc;  // sticky until reset
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= 4'd0;
      r_carry <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
    end else begin
      r_pc <= w_pc_next;
      if (w_carry_we) r_carry <= w_carry_next;
      if (w_reg_we)   r_regs[w_rd] <= w_result;
    end
  end

  assign Instruction = w_instr;
  assign PC          = r_pc;
  assign R0          = r_regs[0];
  assign R1          = r_regs[1];
  assign R2          = r_regs[2];
  assign R3          = r_regs[3];
  assign ALUResult   = w_result;
  assign CarryOut    = r_carry;

endmodule

// File: tb/tb_cpu.sv
// -----------------------------------------------------------------------------
// tb_cpu : self-checking bench for cpu
//
// A behavioural model of the instruction set runs alongside the DUT and every
// output is compared on each falling edge. Hand-computed expectations for the
// built-in program pin the model, and random mid-run resets exercise the
// asynchronous clear and the replay from address 0.
// -----------------------------------------------------------------------------
module tb_cpu;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] Instruction;
  logic [3:0] PC;
  logic [7:0] R0, R1, R2, R3;
  logic [7:0] ALUResult;
  logic       CarryOut;

  always #5 clk = ~clk;

  cpu dut (
    .clk        (clk),
    .reset      (reset),
    .Instruction(Instruction),
    .PC         (PC),
    .R0         (R0),
    .R1         (R1),
    .R2         (R2),
    .R3         (R3),
    .ALUResult  (ALUResult),
    .CarryOut   (CarryOut)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [7:0] ROM [16] = '{
    8'hC3, 8'hC6, 8'h11, 8'h78, 8'hAA, 8'h29, 8'h5E, 8'h6F,
    8'h8C, 8'h1E, 8'hEC, 8'h00, 8'h94, 8'h31, 8'hFF, 8'h00
  };

  int m_pc = 0;
  int m_r [4] = '{0, 0, 0, 0};
  int m_c = 0;

  function automatic int m_alu(input logic [7:0] ins);
    int op = int'(ins[7:4]);
    int a  = m_r[ins[3:2]];
    int b  = m_r[ins[1:0]];
    case (op)
      1:  return (a + b) % 256;
      2:  return (a - b + 256) % 256;
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return 255 - b;
      7:  return b;
      8:  return (a + 1) % 256;
      9:  return (a + 255) % 256;
      10: return (b * 2) % 256;
      11: return b / 2;
      12: return int'(ins[1:0]);
      default: return 0;
    endcase
  endfunction

  function automatic int m_carry_after(input logic [7:0] ins);
    int op = int'(ins[7:4]);
    int a  = m_r[ins[3:2]];
    int b  = m_r[ins[1:0]];
    case (op)
      1:  return (a + b > 255) ? 1 : 0;
      2:  return (a < b) ? 1 : 0;
      8:  return (a == 255) ? 1 : 0;
      9:  return (a == 0) ? 1 : 0;
      10: return (b >= 128) ? 1 : 0;
      11: return b % 2;
      default: return m_c;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0;
      m_c  = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
    end else begin
      logic [7:0] ins;
      int op, res, nc, npc;
      ins = ROM[m_pc];
      op  = int'(ins[7:4]);
      res = m_alu(ins);
      nc  = m_carry_after(ins);
      if (op == 13)      npc = int'(ins[3:0]);
      else if (op == 14) npc = (m_c == 1) ? int'(ins[3:0]) : (m_pc + 1) % 16;
      else if (op == 15) npc = m_pc;
      else               npc = (m_pc + 1) % 16;
      if (op >= 1 && op <= 12) m_r[ins[3:2]] = res;
      m_c  = nc;
      m_pc = npc;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("cmp_pc",    32'(PC),          32'(m_pc));
    chk("cmp_instr", 32'(Instruction), 32'(ROM[m_pc]));
    chk("cmp_alu",   32'(ALUResult),   32'(m_alu(ROM[m_pc])));
    chk("cmp_r0",    32'(R0),          32'(m_r[0]));
    chk("cmp_r1",    32'(R1),          32'(m_r[1]));
    chk("cmp_r2",    32'(R2),          32'(m_r[2]));
    chk("cmp_r3",    32'(R3),          32'(m_r[3]));
    chk("cmp_c",     32'(CarryOut),    32'(m_c));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_pc"},    32'(PC),          32'h0);
    chk({tag, "_r0"},    32'(R0),          32'h00);
    chk({tag, "_r1"},    32'(R1),          32'h00);
    chk({tag, "_r2"},    32'(R2),          32'h00);
    chk({tag, "_r3"},    32'(R3),          32'h00);
    chk({tag, "_c"},     32'(CarryOut),    32'h0);
    chk({tag, "_instr"}, 32'(Instruction), 32'hC3);
    chk({tag, "_alu"},   32'(ALUResult),   32'h03);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    #1 reset = 1'b1;       // asynchronous assertion before any clock edge
    #1 chk_cleared("rst_async");
    #9 chk_cleared("rst_after_edge");  // t=11, posedge at 5 passed with reset high
    #1 reset = 1'b0;       // t=12, first instruction executes at t=15

    // Straight-line program with hand-computed values
    tick(); chk("e1_r0", 32'(R0), 32'h03); chk("e1_pc", 32'(PC), 32'h1);
    tick(); chk("e2_r1", 32'(R1), 32'h02);
    tick(); chk("e3_r0", 32'(R0), 32'h05);
    tick(); chk("e4_r2", 32'(R2), 32'h05);
    tick(); chk("e5_r2", 32'(R2), 32'h0A);
    tick(); chk("e6_r2", 32'(R2), 32'h08); chk("e6_c", 32'(CarryOut), 32'h0);
    tick(); chk("e7_r3", 32'(R3), 32'h08);
    tick(); chk("e8_r3", 32'(R3), 32'hF7);
    tick(); chk("e9_r3", 32'(R3), 32'hF8);
    tick(); chk("add_carry_r3", 32'(R3), 32'h00); chk("add_carry_c", 32'(CarryOut), 32'h1);
    chk("jc_pc_before", 32'(PC), 32'd10);
    tick(); chk("jc_taken_pc", 32'(PC), 32'd12);
    tick(); chk("dec_r1", 32'(R1), 32'h01); chk("dec_c", 32'(CarryOut), 32'h0);
    tick(); chk("and_r0", 32'(R0), 32'h01);
    chk("halt_pc", 32'(PC), 32'd14);
    chk("halt_instr", 32'(Instruction), 32'hFF);

    // Idle while halted
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_pc",  32'(PC),        32'd14);
      chk("idle_alu", 32'(ALUResult), 32'h00);
      chk("idle_r0",  32'(R0),        32'h01);
      chk("idle_r1",  32'(R1),        32'h01);
      chk("idle_r2",  32'(R2),        32'h08);
      chk("idle_r3",  32'(R3),        32'h00);
      chk("idle_c",   32'(CarryOut),  32'h0);
    end

    // Mid-run reset around PC=6
    reset = 1'b1;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (PC == 4'd6) found = 1'b1;
    end
    chk("reach_pc6", 32'(found), 32'h1);
    #2 reset = 1'b1;
    #1 chk_cleared("midrun");
    release_reset();
    tick();
    chk("replay_r0", 32'(R0), 32'h03);
    chk("replay_pc", 32'(PC), 32'h1);

    // Random mid-run resets
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(0, 18)) tick();
      #($urandom_range(1, 2));
      reset = 1'b1;
      #1 chk_cleared("rand_rst");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      release_reset();
    end
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
